// File: rtl/simon_round_core.sv
// Simon 32/64 round datapath: one Feistel round per clock, encrypt or decrypt.
// A block is accepted through a valid/ready handshake. The core runs ROUNDS rounds using
// the externally held round-key array, then holds the result until it is consumed.
module simon_round_core #(
  parameter int unsigned ROUNDS = 32,
  parameter int unsigned WORD   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ROUNDS-1:0][WORD-1:0]  key,
  input  logic                         key_valid,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         dec,
  input  logic [2*WORD-1:0]            din,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2*WORD-1:0]            dout,
  output logic                         busy
);

  localparam int unsigned CntW = 6;
  localparam int unsigned IdxW = $clog2(ROUNDS);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [WORD-1:0]     x_q, x_d, y_q, y_d;
  logic [CntW-1:0]     round_q, round_d;
  logic                dec_q, dec_d;
  logic [2*WORD-1:0]   dout_q, dout_d;

  logic [CntW-1:0]     key_sel;
  logic [WORD-1:0]     kr;
  logic [WORD-1:0]     x_next;

  function automatic logic [WORD-1:0] rotl(input logic [WORD-1:0] v, input int unsigned n);
    return (v << n) | (v >> (WORD - n));
  endfunction

  // Round-key selection and the Feistel round function for the current round.
  always_comb begin
    // Decryption walks the key array backwards.
    key_sel = dec_q ? (CntW'(ROUNDS - 1) - round_q) : round_q;
    kr      = key[key_sel[IdxW-1:0]];
    x_next  = y_q ^ (rotl(x_q, 1) & rotl(x_q, 8)) ^ rotl(x_q, 2) ^ kr;
  end

  // Next-state logic, handshake outputs and datapath updates.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    round_d  = round_q;
    dec_d    = dec_q;
    dout_d   = dout_q;
    in_ready = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = key_valid;
        if (in_valid && key_valid) begin
          dec_d   = dec;
          // Decrypt swaps the halves so the same forward round inverts the cipher.
          x_d     = dec ? din[WORD-1:0] : din[2*WORD-1:WORD];
          y_d     = dec ? din[2*WORD-1:WORD] : din[WORD-1:0];
          round_d = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        x_d     = x_next;
        y_d     = x_q;
        round_d = round_q + 1'b1;
        if (round_q == CntW'(ROUNDS - 1)) begin
          dout_d  = dec_q ? {x_q, x_next} : {x_next, x_q};
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      round_q <= round_d;
      dec_q   <= dec_d;
      dout_q  <= dout_d;
    end
  end

  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign dout      = dout_q;

endmodule

// File: tb/tb_simon_round_core.sv
// Self-checking bench for simon_round_core: directed known-answer tests plus a
// cycle-level reference model compared against the DUT on every negative clock edge.
module tb_simon_round_core;

  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

  logic               clk = 1'b0;
  logic               rst;
  logic [31:0][15:0]  key;
  logic               key_valid;
  logic               in_valid;
  logic               in_ready;
  logic               dec;
  logic [31:0]        din;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        dout;
  logic               busy;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit          mon_en = 1'b0;
  bit          m_idle;
  bit          m_done;
  int          m_left;
  logic [31:0] m_res;
  logic [31:0] m_dout;

  simon_round_core dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .key_valid (key_valid),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dec       (dec),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] simon_f(input logic [15:0] v);
    return ({v[14:0], v[15]} & {v[7:0], v[15:8]}) ^ {v[13:0], v[15:14]};
  endfunction

  function automatic logic [31:0][15:0] expand(input logic [15:0] k0, input logic [15:0] k1,
                                              input logic [15:0] k2, input logic [15:0] k3);
    logic [31:0][15:0] k;
    logic [15:0]       t;
    logic [61:0]       z;
    z    = Z0;
    k    = '0;
    k[0] = k0;
    k[1] = k1;
    k[2] = k2;
    k[3] = k3;
    for (int i = 4; i < 32; i++) begin
      t    = {k[i-1][2:0], k[i-1][15:3]} ^ k[i-3];
      t    = t ^ {t[0], t[15:1]};
      k[i] = ~k[i-4] ^ t ^ {15'd0, z[61-(i-4)]} ^ 16'd3;
    end
    return k;
  endfunction

  function automatic logic [31:0] model_enc(input logic [31:0] pt, input logic [31:0][15:0] k);
    logic [15:0] x, y, t;
    x = pt[31:16];
    y = pt[15:0];
    for (int i = 0; i < 32; i++) begin
      t = x;
      x = y ^ simon_f(x) ^ k[i];
      y = t;
    end
    return {x, y};
  endfunction

  // Inverse rounds applied in reverse order.
  function automatic logic [31:0] model_dec(input logic [31:0] ct, input logic [31:0][15:0] k);
    logic [15:0] x, y, t;
    x = ct[31:16];
    y = ct[15:0];
    for (int i = 31; i >= 0; i--) begin
      t = y;
      y = x ^ simon_f(y) ^ k[i];
      x = t;
    end
    return {x, y};
  endfunction

  // Compare DUT outputs to the model, then advance the model using the inputs the
  // next rising edge will sample.
  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_in_ready", {31'd0, in_ready}, {31'd0, m_idle && key_valid});
      check("mon_busy", {31'd0, busy}, {31'd0, !m_idle});
      check("mon_out_valid", {31'd0, out_valid}, {31'd0, m_done});
      check("mon_dout", dout, m_dout);
      if (rst) begin
        m_idle = 1'b1;
        m_done = 1'b0;
        m_left = 0;
        m_dout = '0;
      end else if (m_idle) begin
        if (in_valid && key_valid) begin
          m_res  = dec ? model_dec(din, key) : model_enc(din, key);
          m_left = 32;
          m_idle = 1'b0;
        end
      end else if (!m_done) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_dout = m_res;
        end
      end else if (out_ready) begin
        m_done = 1'b0;
        m_idle = 1'b1;
      end
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run_block(input logic [31:0] d, input logic dv, output logic [31:0] res);
    int n;
    din      = d;
    dec      = dv;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("accept_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_done(n);
    check("block_latency", 32'(n), 32'd32);
    res       = dout;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0]       held;
    logic [31:0]       res;
    logic [31:0]       pt;
    logic [31:0]       ct;
    logic [31:0][15:0] kat_key;
    int                n;

    rst       = 1'b1;
    key_valid = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dec       = 1'b0;
    din       = '0;
    kat_key   = expand(16'h0100, 16'h0908, 16'h1110, 16'h1918);
    key       = kat_key;
    m_idle    = 1'b1;
    m_done    = 1'b0;
    m_left    = 0;
    m_res     = '0;
    m_dout    = '0;

    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Reset state
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_dout", dout, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);

    // Pin the model to the published vectors
    check("model_enc_kat", model_enc(32'h65656877, kat_key), 32'hc69be9bb);
    check("model_dec_kat", model_dec(32'hc69be9bb, kat_key), 32'h65656877);

    // Key gating: offered block is held off until key_valid rises
    din      = 32'h65656877;
    dec      = 1'b0;
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("gate_in_ready", {31'd0, in_ready}, 32'd0);
      check("gate_busy", {31'd0, busy}, 32'd0);
    end
    key_valid = 1'b1;
    #1;
    check("gate_open", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dec      = 1'b1;  // must not affect the latched direction
    check("enc_busy", {31'd0, busy}, 32'd1);
    n = 0;
    while (!out_valid && n < 100) begin
      key_valid = (n % 3 != 1);
      @(posedge clk);
      #1;
      n++;
    end
    key_valid = 1'b1;
    check("enc_latency", 32'(n), 32'd32);
    check("enc_kat", dout, 32'hc69be9bb);

    // Backpressure with a decrypt request already waiting
    din      = 32'hc69be9bb;
    dec      = 1'b1;
    in_valid = 1'b1;
    held     = dout;
    repeat (10) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_dout_stable", dout, held);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("consume_out_valid", {31'd0, out_valid}, 32'd0);
    check("consume_busy", {31'd0, busy}, 32'd0);
    check("consume_in_ready", {31'd0, in_ready}, 32'd1);
    check("consume_dout_kept", dout, 32'hc69be9bb);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dec      = 1'b0;
    check("dec_busy", {31'd0, busy}, 32'd1);
    wait_done(n);
    check("dec_latency", 32'(n), 32'd32);
    check("dec_kat", dout, 32'h65656877);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Reset in the middle of a block
    din      = 32'h12345678;
    dec      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_dout", dout, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    run_block(32'h65656877, 1'b0, res);
    check("post_rst_kat", res, 32'hc69be9bb);

    // Random round trips under a fresh master key
    key = expand(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    for (int i = 0; i < 50; i++) begin
      pt = $urandom;
      run_block(pt, 1'b0, ct);
      check("rt_enc", ct, model_enc(pt, key));
      run_block(ct, 1'b1, res);
      check("rt_dec", res, pt);
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simon_round_core.md
Name: simon_round_core

Overview:
- Simon 32/64 block-cipher datapath: one Feistel round per clock.
- Sits directly downstream of the key-schedule block and consumes its 32 x 16-bit round-key array.
- Accepts a 32-bit block through a valid/ready handshake, runs 32 rounds and presents the result through a valid/ready handshake.
- Supports encrypt and decrypt (reverse key order) so one instance serves both directions.

Parameters:
- ROUNDS, 32, number of rounds; also the depth of the key array (fixed at 32 for Simon 32/64).
- WORD, 16, half-block and round-key width in bits.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- key  input  [ROUNDS-1:0][WORD-1:0]  round-key array; key[i] is the round-i key as produced by the key schedule.
- key_valid  input  1  key array is complete and stable; gates acceptance only.
- in_valid  input  1  block offered.
- in_ready  output  1  core can accept a block.
- dec  input  1  sampled with the block; 0 = encrypt, 1 = decrypt.
- din  input  2*WORD  plaintext (encrypt) or ciphertext (decrypt); upper word = x.
- out_valid  output  1  result held on dout.
- out_ready  input  1  downstream accepts the result.
- dout  output  2*WORD  ciphertext (encrypt) or plaintext (decrypt).
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst=1 at an edge), taking priority over everything including mid-operation:
  - state = IDLE; x, y, round counter, dec_q and dout cleared to 0.
  - out_valid = 0, busy = 0; any in-flight block is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = key_valid. in_ready is combinational and 0 in every other state.
  - On in_valid && in_ready at an edge, latch dec_q = dec.
  - Encrypt load: x = din[31:16], y = din[15:0].
  - Decrypt load: x = din[15:0], y = din[31:16] (halves swapped).
  - Set round = 0 and go to RUN.
- RUN, on each edge:
  - kr = key[round] when encrypting, key[ROUNDS-1-round] when decrypting.
  - x_next = y ^ (rotl1(x) & rotl8(x)) ^ rotl2(x) ^ kr; y_next = x.
  - round increments by 1.
  - When round == ROUNDS-1 the final round is applied, dout is loaded and state goes to DONE.
- Output word, computed from the post-round values:
  - encrypt: dout = {x_next, y_next}.
  - decrypt: dout = {y_next, x_next} (halves swapped back).
- Round counter: 6 bits wide; never wraps in normal operation; it is reset to 0 on every accept.
- Latency: exactly ROUNDS edges in RUN. out_valid is first high in the cycle after the ROUNDS-th edge following the accept edge, i.e. 32 cycles after acceptance.
- DONE:
  - out_valid = 1; dout holds stable while out_ready = 0 (backpressure of any length).
  - On out_valid && out_ready at an edge: out_valid -> 0 and state -> IDLE.
  - dout keeps its last value until the next completion or reset.
- No overlap: a new block cannot be accepted in the same cycle the result is consumed. in_ready first rises in the cycle after the DONE->IDLE edge.
- key and key_valid during RUN:
  - Key words are read combinationally each round, so the caller holds key stable from accept to DONE.
  - Dropping key_valid during RUN or DONE has no effect on the operation in flight.
- in_valid asserted while busy is ignored; there is no buffering.
- dec changes after acceptance have no effect because dec_q is latched.
- Rotations are within WORD bits; all XOR/AND are WORD bits wide; there is no carry arithmetic.

Test Plan:
- Encrypt known answer: key = {k0,k1,k2,k3} = 0100,0908,1110,1918 expanded by the key schedule; din = 32'h65656877, dec = 0 -> dout = 32'hc69be9bb with out_valid exactly 32 cycles after acceptance.
- Decrypt known answer: same keys, din = 32'hc69be9bb, dec = 1 -> dout = 32'h65656877.
- Backpressure: hold out_ready = 0 for 10 cycles after completion -> out_valid stays 1, dout stays stable, in_ready stays 0; a single out_ready pulse -> IDLE next cycle, then accept a second block and check its result.
- Key gating: key_valid = 0 with in_valid = 1 -> in_ready = 0 and no accept; raise key_valid -> accepted on that edge. Toggling key_valid mid-RUN leaves the result unchanged.
- Reset mid-operation: assert rst at round 15 -> next cycle busy = 0, out_valid = 0, dout = 0, in_ready = key_valid; a subsequent block still produces the correct answer.
- Back-to-back random round trip: encrypt then decrypt 50 random blocks -> recovered block equals the original; compare against a reference model.
